wb_bus_arbiter: RTL and testbench
=================================

WB_BUS_ARBITER -- requirements
Module: wb_bus_arbiter

Interface
REQ-001 SHALL provide parameter TIMEOUT, default 15: number of strobed cycles without ACK before an error is forced (range 2..255).
REQ-002 SHALL provide port CLK_I, in, 1: system clock; all state changes on its rising edge.
REQ-003 SHALL provide port RES_I, in, 1: reset, asynchronous and active-high.
REQ-004 SHALL provide ports M0_CYC_I/M1_CYC_I, in, 1: master 0 (CPU) and master 1 (DMA/video) bus request.
REQ-005 SHALL provide ports M0_STB_I/M1_STB_I, in, 1: master transfer strobe.
REQ-006 SHALL provide ports M0_WE_I/M1_WE_I, in, 1: master write enable.
REQ-007 SHALL provide ports M0_ADR_I/M1_ADR_I, in, 15: word address bits [15:1].
REQ-008 SHALL provide ports M0_SEL_I/M1_SEL_I, in, 2: byte lane selects; [0] is the even byte, [1] is the odd byte.
REQ-009 SHALL provide ports M0_DAT_I/M1_DAT_I, in, 16: master write data.
REQ-010 SHALL provide ports M0_DAT_O/M1_DAT_O, out, 16: read data returned to each master.
REQ-011 SHALL provide ports M0_ACK_O/M1_ACK_O, out, 1: transfer acknowledge.
REQ-012 SHALL provide ports M0_ERR_O/M1_ERR_O, out, 1: transfer error.
REQ-013 SHALL provide ports S_ADR_O 15, S_DAT_O 16, S_WE_O 1 and S_SEL_O 2, all out: shared bus signals muxed from the granted master.
REQ-014 SHALL provide ports RAM_STB_O, LED_STB_O and KIA_STB_O, out, 1 each: per-slave strobes.
REQ-015 SHALL provide ports RAM_DAT_I 16 and KIA_DAT_I 8, in: slave read data.
REQ-016 SHALL provide port KIA_ACK_I, in, 1: keyboard interface acknowledge.
REQ-017 SHALL provide port GNT_O, out, 2: one-hot grant; bit 0 is master 0, bit 1 is master 1.

Function
REQ-018 SHALL implement an FSM with states IDLE, OWN0 and OWN1; GNT_O is 2'b01 in OWN0, 2'b10 in OWN1, 2'b00 in IDLE, and is decoded directly from registered state.
REQ-019 SHALL arbitrate from IDLE as follows:
- only M0_CYC_I high -> OWN0;
- only M1_CYC_I high -> OWN1;
- both high -> the master not granted last (round-robin);
- the last-grant register resets to master 1, so master 0 wins the first tie.
REQ-020 SHALL hold OWNn while Mn_CYC_I is high and return to IDLE on the first edge that samples it low; a new grant therefore always passes through one IDLE cycle.
REQ-021 SHALL give a latency of exactly one edge from a CYC rise in IDLE to the GNT_O update; slave strobes are available from the following cycle.
REQ-022 SHALL decode combinationally on the granted master's ADR[15:12], with active = granted CYC & STB:
- 0 -> RAM_STB_O;
- 1 -> LED_STB_O;
- 2 -> KIA_STB_O, additionally qualified by SEL[0];
- 3..F -> unmapped.
REQ-023 SHALL generate the RAM/LED acknowledge internally as a registered toggle, int_ack <= ~int_ack & (RAM_STB_O | LED_STB_O): ACK appears on the second strobed cycle and is low on the third, so back-to-back accesses alternate.
REQ-024 SHALL route the acknowledge source as follows: KIA_ACK_I is used for the KIA region; an unmapped access raises ERR as a registered one-cycle pulse on the second strobed cycle, using the same toggle behaviour as REQ-023.
REQ-025 SHALL drive the granted master's DAT_O with RAM_DAT_I for the RAM region, {8'h00, KIA_DAT_I} for the KIA region, and 16'h0000 otherwise.
REQ-026 SHALL hold the non-granted master's DAT_O, ACK_O and ERR_O at 0 at all times.
REQ-027 SHALL drive S_* from the granted master, and to 0 in IDLE.
REQ-028 SHALL run an 8-bit watchdog with these rules:
- increment on each cycle where any strobe is active (including unmapped) and neither ACK nor ERR is returned;
- clear on ACK, ERR, or a strobe-inactive cycle;
- on reaching TIMEOUT-1, assert ERR to the granted master for one cycle and clear.
REQ-029 SHALL give ERR priority over ACK if both occur in the same cycle; ACK is suppressed.
REQ-030 SHALL, when the granted master drops STB with CYC held, clear int_ack and the watchdog and keep the grant.
REQ-031 SHALL, when the granted master drops CYC in the same cycle as its ACK, still deliver the ACK that cycle and go to IDLE at the edge.

Reset
REQ-032 SHALL, while RES_I is high, asynchronously force:
- state IDLE, last-grant = master 1;
- int_ack, error toggle and watchdog = 0;
- consequently GNT_O = 2'b00, all slave strobes, ACK_O and ERR_O = 0, DAT_O = 0.
REQ-033 SHALL, on reset asserted mid-transfer, abort the transfer with no ACK/ERR issued; arbitration resumes on the first edge after RES_I falls.

Verification
REQ-034 SHALL cover: M0 reads ADR=15'h0010 (RAM) -> GNT_O=01 one edge after CYC; RAM_STB_O high; M0_ACK_O high on the 2nd strobed cycle with M0_DAT_O=RAM_DAT_I.
REQ-035 SHALL cover: M0 and M1 raise CYC on the same edge from reset -> M0 is granted first; after M0 drops CYC, one IDLE cycle, then GNT_O=10.
REQ-036 SHALL cover: M1 reads KIA (ADR[15:12]=2, SEL=01), KIA_DAT_I=8'h5A, KIA_ACK_I held 3 cycles -> M1_DAT_O=16'h005A; M0 outputs stay 0.
REQ-037 SHALL cover: M0 accesses ADR[15:12]=4 -> M0_ERR_O one-cycle pulse on the 2nd strobed cycle; no slave strobe.
REQ-038 SHALL cover: KIA access with SEL=10 and KIA_ACK_I never asserted, TIMEOUT=15 -> watchdog asserts M0_ERR_O exactly on the 15th strobed cycle.
REQ-039 SHALL cover: RES_I raised mid-RAM-access -> GNT_O and RAM_STB_O fall without a clock edge; no ACK is delivered.

Source files
------------

// File: rtl/wb_bus_arbiter.sv
// rtl/wb_bus_arbiter.sv - two-master Wishbone arbiter with RAM/LED/KIA decode and watchdog
module wb_bus_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        CLK_I,
    input  logic        RES_I,
    input  logic        M0_CYC_I,
    input  logic        M0_STB_I,
    input  logic        M0_WE_I,
    input  logic [14:0] M0_ADR_I,
    input  logic [1:0]  M0_SEL_I,
    input  logic [15:0] M0_DAT_I,
    output logic [15:0] M0_DAT_O,
    output logic        M0_ACK_O,
    output logic        M0_ERR_O,
    input  logic        M1_CYC_I,
    input  logic        M1_STB_I,
    input  logic        M1_WE_I,
    input  logic [14:0] M1_ADR_I,
    input  logic [1:0]  M1_SEL_I,
    input  logic [15:0] M1_DAT_I,
    output logic [15:0] M1_DAT_O,
    output logic        M1_ACK_O,
    output logic        M1_ERR_O,
    output logic [14:0] S_ADR_O,
    output logic [15:0] S_DAT_O,
    output logic        S_WE_O,
    output logic [1:0]  S_SEL_O,
    output logic        RAM_STB_O,
    output logic        LED_STB_O,
    output logic        KIA_STB_O,
    input  logic [15:0] RAM_DAT_I,
    input  logic [7:0]  KIA_DAT_I,
    input  logic        KIA_ACK_I,
    output logic [1:0]  GNT_O
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    logic        last_m1;
    logic        int_ack;
    logic        err_tgl;
    logic [7:0]  wdog;

    logic        g_cyc;
    logic        g_stb;
    logic        g_we;
    logic [14:0] g_adr;
    logic [1:0]  g_sel;
    logic [15:0] g_dat;
    logic [3:0]  region;
    logic        active;
    logic        unmapped;
    logic        ramled_ack;
    logic        kia_ack;
    logic        wd_err;
    logic        bus_err;
    logic        bus_ack;
    logic [15:0] rd_data;

    always_comb begin
        g_cyc = 1'b0;
        g_stb = 1'b0;
        g_we  = 1'b0;
        g_adr = '0;
        g_sel = '0;
        g_dat = '0;
        case (state)
            OWN0: begin
                g_cyc = M0_CYC_I;
                g_stb = M0_STB_I;
                g_we  = M0_WE_I;
                g_adr = M0_ADR_I;
                g_sel = M0_SEL_I;
                g_dat = M0_DAT_I;
            end
            OWN1: begin
                g_cyc = M1_CYC_I;
                g_stb = M1_STB_I;
                g_we  = M1_WE_I;
                g_adr = M1_ADR_I;
                g_sel = M1_SEL_I;
                g_dat = M1_DAT_I;
            end
            default: ;
        endcase
    end

    // ADR carries byte-address bits [15:1], so [14:11] is the 4 KiB region
    assign region    = g_adr[14:11];
    assign active    = g_cyc & g_stb;
    assign RAM_STB_O = active & (region == 4'h0);
    assign LED_STB_O = active & (region == 4'h1);
    assign KIA_STB_O = active & (region == 4'h2) & g_sel[0];
    assign unmapped  = active & (region >= 4'h3);

    assign ramled_ack = int_ack & (RAM_STB_O | LED_STB_O);
    assign kia_ack    = KIA_STB_O & KIA_ACK_I;
    assign wd_err     = active & (wdog == WD_LAST);
    assign bus_err    = (err_tgl & unmapped) | wd_err;
    assign bus_ack    = (ramled_ack | kia_ack) & ~bus_err;

    always_comb begin
        rd_data = 16'h0000;
        if (region == 4'h0)
            rd_data = RAM_DAT_I;
        else if (region == 4'h2)
            rd_data = {8'h00, KIA_DAT_I};
    end

    assign GNT_O    = {state == OWN1, state == OWN0};
    assign S_ADR_O  = g_adr;
    assign S_DAT_O  = g_dat;
    assign S_WE_O   = g_we;
    assign S_SEL_O  = g_sel;

    assign M0_DAT_O = (state == OWN0) ? rd_data : 16'h0000;
    assign M0_ACK_O = (state == OWN0) & bus_ack;
    assign M0_ERR_O = (state == OWN0) & bus_err;
    assign M1_DAT_O = (state == OWN1) ? rd_data : 16'h0000;
    assign M1_ACK_O = (state == OWN1) & bus_ack;
    assign M1_ERR_O = (state == OWN1) & bus_err;

    always_ff @(posedge CLK_I or posedge RES_I) begin
        if (RES_I) begin
            state   <= IDLE;
            last_m1 <= 1'b1;
            int_ack <= 1'b0;
            err_tgl <= 1'b0;
            wdog    <= 8'd0;
        end else begin
            // toggles make every second strobed cycle the completing one
            int_ack <= ~int_ack & (RAM_STB_O | LED_STB_O);
            err_tgl <= ~err_tgl & unmapped;
            if (!active || ramled_ack || kia_ack || bus_err)
                wdog <= 8'd0;
            else
                wdog <= wdog + 8'd1;

            case (state)
                IDLE: begin
                    if (M0_CYC_I && (!M1_CYC_I || last_m1)) begin
                        state   <= OWN0;
                        last_m1 <= 1'b0;
                    end else if (M1_CYC_I) begin
                        state   <= OWN1;
                        last_m1 <= 1'b1;
                    end
                end
                OWN0: if (!M0_CYC_I) state <= IDLE;
                OWN1: if (!M1_CYC_I) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb/tb_wb_bus_arbiter.sv - directed and randomized bench for wb_bus_arbiter
module tb_wb_bus_arbiter;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cyc, m0_stb, m0_we;
    logic [14:0] m0_adr;
    logic [1:0]  m0_sel;
    logic [15:0] m0_wdat, m0_rdat;
    logic        m0_ack, m0_err;
    logic        m1_cyc, m1_stb, m1_we;
    logic [14:0] m1_adr;
    logic [1:0]  m1_sel;
    logic [15:0] m1_wdat, m1_rdat;
    logic        m1_ack, m1_err;
    logic [14:0] s_adr;
    logic [15:0] s_dat;
    logic        s_we;
    logic [1:0]  s_sel;
    logic        ram_stb, led_stb, kia_stb;
    logic [15:0] ram_dat;
    logic [7:0]  kia_dat;
    logic        kia_ack;
    logic [1:0]  gnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_bus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .CLK_I(clk), .RES_I(rst),
        .M0_CYC_I(m0_cyc), .M0_STB_I(m0_stb), .M0_WE_I(m0_we), .M0_ADR_I(m0_adr),
        .M0_SEL_I(m0_sel), .M0_DAT_I(m0_wdat), .M0_DAT_O(m0_rdat), .M0_ACK_O(m0_ack), .M0_ERR_O(m0_err),
        .M1_CYC_I(m1_cyc), .M1_STB_I(m1_stb), .M1_WE_I(m1_we), .M1_ADR_I(m1_adr),
        .M1_SEL_I(m1_sel), .M1_DAT_I(m1_wdat), .M1_DAT_O(m1_rdat), .M1_ACK_O(m1_ack), .M1_ERR_O(m1_err),
        .S_ADR_O(s_adr), .S_DAT_O(s_dat), .S_WE_O(s_we), .S_SEL_O(s_sel),
        .RAM_STB_O(ram_stb), .LED_STB_O(led_stb), .KIA_STB_O(kia_stb),
        .RAM_DAT_I(ram_dat), .KIA_DAT_I(kia_dat), .KIA_ACK_I(kia_ack), .GNT_O(gnt)
    );

    task automatic clear_inputs();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_sel = '0; m0_wdat = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_sel = '0; m1_wdat = '0;
        ram_dat = '0; kia_dat = '0; kia_ack = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    function automatic logic [14:0] rand_adr();
        logic [3:0] r;
        case ($urandom_range(6))
            0: r = 4'h0;
            1: r = 4'h1;
            2, 3: r = 4'h2;
            4: r = 4'h3;
            5: r = 4'h4;
            default: r = 4'hF;
        endcase
        return {r, 11'($urandom)};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1; ram_dat = 16'h1234; kia_ack = 1;
        repeat (3) @(negedge clk);
        checks++;
        if (gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
        checks++;
        if ({ram_stb, led_stb, kia_stb} !== 3'b000) begin
            failures++; $display("FAIL reset_strobes got=%b exp=000", {ram_stb, led_stb, kia_stb});
        end
        checks++;
        if ({m0_rdat, m0_ack, m0_err, m1_rdat, m1_ack, m1_err} !== 36'h0) begin
            failures++; $display("FAIL reset_master_out got=%h exp=0", {m0_rdat, m0_ack, m0_err, m1_rdat, m1_ack, m1_err});
        end
        checks++;
        if ({s_adr, s_dat, s_we, s_sel} !== 34'h0) begin
            failures++; $display("FAIL reset_sbus got=%h exp=0", {s_adr, s_dat, s_we, s_sel});
        end
    endtask

    task automatic test_ram_read();
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_adr = 15'h0010; m0_sel = 2'b11; ram_dat = 16'hBEEF;
        @(negedge clk);
        checks++;
        if (gnt !== 2'b00) begin failures++; $display("FAIL ram_latency got=%b exp=00", gnt); end
        @(negedge clk);
        checks++;
        if ({gnt, ram_stb, led_stb, kia_stb, m0_ack, m0_err} !== 7'b01_100_00) begin
            failures++; $display("FAIL ram_cycle1 got=%b exp=0110000", {gnt, ram_stb, led_stb, kia_stb, m0_ack, m0_err});
        end
        checks++;
        if (s_adr !== 15'h0010) begin failures++; $display("FAIL ram_sadr got=%h exp=0010", s_adr); end
        @(negedge clk);
        checks++;
        if ({m0_ack, m0_err, m0_rdat} !== {2'b10, 16'hBEEF}) begin
            failures++; $display("FAIL ram_cycle2 got=%b/%b/%h exp=1/0/beef", m0_ack, m0_err, m0_rdat);
        end
        checks++;
        if ({m1_rdat, m1_ack, m1_err} !== 18'h0) begin
            failures++; $display("FAIL ram_m1_quiet got=%h exp=0", {m1_rdat, m1_ack, m1_err});
        end
        @(negedge clk);
        checks++;
        if (m0_ack !== 1'b0) begin failures++; $display("FAIL ram_cycle3 got=%b exp=0", m0_ack); end
        @(posedge clk); #1 clear_inputs();
        repeat (2) @(negedge clk);
        checks++;
        if (gnt !== 2'b00) begin failures++; $display("FAIL ram_release got=%b exp=00", gnt); end
    endtask

    task automatic test_tie();
        do_reset();
        m0_cyc = 1; m1_cyc = 1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (gnt !== 2'b01) begin failures++; $display("FAIL tie_first got=%b exp=01", gnt); end
        @(posedge clk); #1 m0_cyc = 0;
        @(negedge clk);
        checks++;
        if (gnt !== 2'b01) begin failures++; $display("FAIL tie_hold got=%b exp=01", gnt); end
        @(negedge clk);
        checks++;
        if (gnt !== 2'b00) begin failures++; $display("FAIL tie_idle_gap got=%b exp=00", gnt); end
        @(negedge clk);
        checks++;
        if (gnt !== 2'b10) begin failures++; $display("FAIL tie_second got=%b exp=10", gnt); end
        @(posedge clk); #1 clear_inputs();
    endtask

    task automatic test_kia_read();
        do_reset();
        m1_cyc = 1; m1_stb = 1; m1_adr = 15'h1000; m1_sel = 2'b01; kia_dat = 8'h5A;
        repeat (2) @(negedge clk);
        checks++;
        if ({gnt, kia_stb, m1_ack} !== 4'b10_1_0) begin
            failures++; $display("FAIL kia_strobe got=%b exp=1010", {gnt, kia_stb, m1_ack});
        end
        @(posedge clk); #1 kia_ack = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({m1_ack, m1_err, m1_rdat} !== {2'b10, 16'h005A}) begin
                failures++; $display("FAIL kia_ack%0d got=%b/%b/%h exp=1/0/005a", i, m1_ack, m1_err, m1_rdat);
            end
            checks++;
            if ({m0_rdat, m0_ack, m0_err} !== 18'h0) begin
                failures++; $display("FAIL kia_m0_quiet%0d got=%h exp=0", i, {m0_rdat, m0_ack, m0_err});
            end
        end
        @(posedge clk); #1 clear_inputs();
    endtask

    task automatic test_unmapped();
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_adr = 15'h2000; m0_sel = 2'b11;
        repeat (2) @(negedge clk);
        checks++;
        if ({ram_stb, led_stb, kia_stb, m0_ack, m0_err} !== 5'b0) begin
            failures++; $display("FAIL unmapped_c1 got=%b exp=00000", {ram_stb, led_stb, kia_stb, m0_ack, m0_err});
        end
        @(negedge clk);
        checks++;
        if ({m0_ack, m0_err} !== 2'b01) begin failures++; $display("FAIL unmapped_c2 got=%b exp=01", {m0_ack, m0_err}); end
        @(negedge clk);
        checks++;
        if (m0_err !== 1'b0) begin failures++; $display("FAIL unmapped_c3 got=%b exp=0", m0_err); end
        @(posedge clk); #1 clear_inputs();
    endtask

    task automatic test_watchdog();
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_adr = 15'h1000; m0_sel = 2'b10;
        @(negedge clk);
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            checks++;
            if ({m0_err, m0_ack, kia_stb} !== {(i % TIMEOUT) == 0, 2'b00}) begin
                failures++; $display("FAIL watchdog_cycle%0d got=%b exp=%b", i, {m0_err, m0_ack, kia_stb}, {(i % TIMEOUT) == 0, 2'b00});
            end
        end
        @(posedge clk); #1 clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_adr = 15'h0020; ram_dat = 16'hA5A5;
        repeat (2) @(negedge clk);
        checks++;
        if ({gnt, ram_stb} !== 3'b011) begin failures++; $display("FAIL rstmid_pre got=%b exp=011", {gnt, ram_stb}); end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({gnt, ram_stb, m0_ack} !== 4'b0) begin
            failures++; $display("FAIL rstmid_async got=%b exp=0000", {gnt, ram_stb, m0_ack});
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({gnt, m0_ack, m0_err} !== 4'b0) begin
                failures++; $display("FAIL rstmid_held%0d got=%b exp=0000", i, {gnt, m0_ack, m0_err});
            end
        end
        #2 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({gnt, m0_ack} !== 3'b010) begin failures++; $display("FAIL rstmid_resume got=%b exp=010", {gnt, m0_ack}); end
        @(negedge clk);
        checks++;
        if (m0_ack !== 1'b1) begin failures++; $display("FAIL rstmid_ack got=%b exp=1", m0_ack); end
        @(posedge clk); #1 clear_inputs();
    endtask

    // reference model: owner/last-winner bookkeeping plus run lengths of strobed cycles
    task automatic test_random(input int n);
        int own, last, run_rl, run_um, wd, rem0, rem1;
        logic g_cyc, g_stb, g_we, act, e_ram, e_led, e_kia, e_unm, a_raw, e_err, e_ack;
        logic [14:0] g_adr;
        logic [1:0]  g_sel, e_gnt;
        logic [15:0] g_dat, e_rd;
        logic [3:0]  r4;
        do_reset();
        own = 0; last = 1; run_rl = 0; run_um = 0; wd = 0; rem0 = 0; rem1 = 0;
        for (int c = 0; c < n; c++) begin
            if (rem0 == 0 && $urandom_range(2) == 0) begin
                rem0 = int'($urandom_range(40, 1)); m0_adr = rand_adr(); m0_sel = 2'($urandom); m0_we = 1'($urandom);
            end
            if (rem1 == 0 && $urandom_range(2) == 0) begin
                rem1 = int'($urandom_range(40, 1)); m1_adr = rand_adr(); m1_sel = 2'($urandom); m1_we = 1'($urandom);
            end
            m0_cyc = rem0 > 0; m0_stb = m0_cyc && ($urandom_range(7) != 0); m0_wdat = 16'($urandom);
            m1_cyc = rem1 > 0; m1_stb = m1_cyc && ($urandom_range(7) != 0); m1_wdat = 16'($urandom);
            ram_dat = 16'($urandom); kia_dat = 8'($urandom); kia_ack = ($urandom_range(3) == 0);
            @(negedge clk);

            g_cyc = 0; g_stb = 0; g_we = 0; g_adr = '0; g_sel = '0; g_dat = '0; e_gnt = 2'b00;
            if (own == 1) begin
                g_cyc = m0_cyc; g_stb = m0_stb; g_we = m0_we; g_adr = m0_adr; g_sel = m0_sel; g_dat = m0_wdat; e_gnt = 2'b01;
            end else if (own == 2) begin
                g_cyc = m1_cyc; g_stb = m1_stb; g_we = m1_we; g_adr = m1_adr; g_sel = m1_sel; g_dat = m1_wdat; e_gnt = 2'b10;
            end
            r4    = g_adr[14:11];
            act   = g_cyc && g_stb;
            e_ram = act && r4 == 4'h0;
            e_led = act && r4 == 4'h1;
            e_kia = act && r4 == 4'h2 && g_sel[0];
            e_unm = act && r4 >= 4'h3;
            a_raw = ((e_ram || e_led) && (run_rl % 2 == 1)) || (e_kia && kia_ack);
            e_err = (e_unm && (run_um % 2 == 1)) || (act && wd == TIMEOUT - 1);
            e_ack = a_raw && !e_err;
            e_rd  = (r4 == 4'h0) ? ram_dat : (r4 == 4'h2) ? {8'h00, kia_dat} : 16'h0000;

            checks++;
            if (gnt !== e_gnt) begin failures++; $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, gnt, e_gnt); end
            checks++;
            if ({ram_stb, led_stb, kia_stb} !== {e_ram, e_led, e_kia}) begin
                failures++; $display("FAIL rnd_strobes c=%0d got=%b exp=%b", c, {ram_stb, led_stb, kia_stb}, {e_ram, e_led, e_kia});
            end
            checks++;
            if ({s_adr, s_dat, s_we, s_sel} !== {g_adr, g_dat, g_we, g_sel}) begin
                failures++; $display("FAIL rnd_sbus c=%0d got=%h exp=%h", c, {s_adr, s_dat, s_we, s_sel}, {g_adr, g_dat, g_we, g_sel});
            end
            checks++;
            if ({m0_rdat, m0_ack, m0_err} !== ((own == 1) ? {e_rd, e_ack, e_err} : 18'h0)) begin
                failures++; $display("FAIL rnd_m0 c=%0d got=%h/%b/%b exp=%h/%b/%b own=%0d", c, m0_rdat, m0_ack, m0_err, e_rd, e_ack, e_err, own);
            end
            checks++;
            if ({m1_rdat, m1_ack, m1_err} !== ((own == 2) ? {e_rd, e_ack, e_err} : 18'h0)) begin
                failures++; $display("FAIL rnd_m1 c=%0d got=%h/%b/%b exp=%h/%b/%b own=%0d", c, m1_rdat, m1_ack, m1_err, e_rd, e_ack, e_err, own);
            end

            run_rl = (e_ram || e_led) ? run_rl + 1 : 0;
            run_um = e_unm ? run_um + 1 : 0;
            wd     = (!act || a_raw || e_err) ? 0 : wd + 1;
            if (own == 0) begin
                if (m0_cyc && m1_cyc) own = (last == 0) ? 2 : 1;
                else if (m0_cyc)      own = 1;
                else if (m1_cyc)      own = 2;
                if (own != 0) last = own - 1;
            end else if ((own == 1 && !m0_cyc) || (own == 2 && !m1_cyc)) begin
                own = 0;
            end
            if (rem0 > 0) rem0--;
            if (rem1 > 0) rem1--;
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_ram_read();
        test_tie();
        test_kia_read();
        test_unmapped();
        test_watchdog();
        test_reset_mid();
        test_random(3000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
